boot_copy_ctrl: RTL and testbench

Sequencer that owns the 256-byte bootstrap ROM after reset. It holds the 6502 halted and streams LEN ROM bytes into system RAM at DEST_BASE. It then releases the CPU and hands the ROM port to the CPU for direct reads. It sits between the CPU bus mux, the bootstrap ROM and the RAM write port; the top level uses cpu_halt both as CPU RDY-low and as the RAM-bus select.

---
 rtl/boot_pkg.sv | 15 +
 rtl/boot_copy_ctrl.sv | 99 +++++++++
 tb/tb_boot_copy_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the bootstrap copier: FSM state encoding and the
// default memory-map constants used by the top level and the ROM image build.
package boot_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COPY  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [15:0] DEST_BASE_DEF = 16'hFF00;
   localparam int          LEN_DEF       = 256;

endpackage

// File: rtl/boot_copy_ctrl.sv
// Bootstrap copier: holds the CPU halted, streams LEN ROM bytes into RAM at
// DEST_BASE, then releases the CPU and hands it the ROM port.
module boot_copy_ctrl
   import boot_pkg::*;
#(
   parameter logic [15:0] DEST_BASE = DEST_BASE_DEF,
   parameter int          LEN       = LEN_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   output logic [7:0]  rom_addr,
   output logic        rom_cs,
   input  logic [7:0]  rom_dbr,
   input  logic [7:0]  cpu_rom_addr,
   input  logic        cpu_rom_cs,
   output logic [7:0]  cpu_rom_dbr,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_dbw,
   output logic        ram_we,
   output logic        cpu_halt,
   output logic        done
);

   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

   state_t     state;
   logic [7:0] rd_idx;
   logic       vld_p1;
   logic [7:0] wr_off_p1;
   logic       halt_q;
   logic       done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rd_idx <= 8'd0;
         vld_p1 <= 1'b0;
         halt_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         case (state)
            IDLE: begin
               state  <= COPY;
               rd_idx <= 8'd0;
            end
            COPY: begin
               // 8-bit index: LEN=256 ends on 255 without needing a wider compare
               rd_idx <= rd_idx + 8'd1;
               vld_p1 <= 1'b1;
               if (rd_idx == LAST_IDX)
                  state <= DRAIN;
            end
            DRAIN: begin
               state  <= DONE;
               halt_q <= 1'b0;
               done_q <= 1'b1;
            end
            DONE: begin
               if (restart) begin
                  state  <= COPY;
                  rd_idx <= 8'd0;
                  halt_q <= 1'b1;
                  done_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p1: ROM read of offset k lands in RAM one cycle later
   always_ff @(posedge clk) begin
      if (state == COPY)
         wr_off_p1 <= rd_idx;
   end

   always_comb begin
      rom_addr = rd_idx;
      rom_cs   = 1'b0;
      case (state)
         COPY: rom_cs = 1'b1;
         DONE: begin
            rom_addr = cpu_rom_addr;
            rom_cs   = cpu_rom_cs;
         end
         default: ;
      endcase
   end

   assign cpu_rom_dbr = rom_dbr;
   assign ram_we      = vld_p1;
   assign ram_addr    = DEST_BASE + {8'h00, wr_off_p1};
   assign ram_dbw     = rom_dbr;
   assign cpu_halt    = halt_q;
   assign done        = done_q;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Bench for boot_copy_ctrl: a default instance and a wrapped 32-byte instance,
// each with a registered ROM model and a write scoreboard.
module tb_boot_copy_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [7:0] rom_val(input logic [7:0] i);
      return i ^ 8'hA5;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   // instance A: defaults
   logic        rst_a = 1'b1, restart_a = 1'b0, rom_cs_a, cpu_rom_cs_a = 1'b0;
   logic [7:0]  rom_addr_a, rom_dbr_a = 8'h00, cpu_rom_addr_a = 8'h00, cpu_rom_dbr_a, ram_dbw_a;
   logic [15:0] ram_addr_a;
   logic        ram_we_a, cpu_halt_a, done_a;
   logic [7:0]  ram_a [0:65535];
   logic [23:0] q_a[$];

   boot_copy_ctrl dut_a (
      .clk(clk), .rst(rst_a), .restart(restart_a),
      .rom_addr(rom_addr_a), .rom_cs(rom_cs_a), .rom_dbr(rom_dbr_a),
      .cpu_rom_addr(cpu_rom_addr_a), .cpu_rom_cs(cpu_rom_cs_a), .cpu_rom_dbr(cpu_rom_dbr_a),
      .ram_addr(ram_addr_a), .ram_dbw(ram_dbw_a), .ram_we(ram_we_a),
      .cpu_halt(cpu_halt_a), .done(done_a)
   );

   // instance B: wrapping destination, short length
   logic        rst_b = 1'b1, restart_b = 1'b0, rom_cs_b;
   logic [7:0]  rom_addr_b, rom_dbr_b = 8'h00, cpu_rom_dbr_b, ram_dbw_b;
   logic [15:0] ram_addr_b;
   logic        ram_we_b, cpu_halt_b, done_b;
   logic [7:0]  ram_b [0:65535];
   logic [23:0] q_b[$];

   boot_copy_ctrl #(.DEST_BASE(16'hFFF0), .LEN(32)) dut_b (
      .clk(clk), .rst(rst_b), .restart(restart_b),
      .rom_addr(rom_addr_b), .rom_cs(rom_cs_b), .rom_dbr(rom_dbr_b),
      .cpu_rom_addr(8'h00), .cpu_rom_cs(1'b0), .cpu_rom_dbr(cpu_rom_dbr_b),
      .ram_addr(ram_addr_b), .ram_dbw(ram_dbw_b), .ram_we(ram_we_b),
      .cpu_halt(cpu_halt_b), .done(done_b)
   );

   // registered ROMs and RAMs
   always @(posedge clk) begin
      if (rom_cs_a) rom_dbr_a <= rom_val(rom_addr_a);
      if (rom_cs_b) rom_dbr_b <= rom_val(rom_addr_b);
      if (ram_we_a) ram_a[ram_addr_a] <= ram_dbw_a;
      if (ram_we_b) ram_b[ram_addr_b] <= ram_dbw_b;
   end

   // write monitors
   always @(negedge clk) begin
      if (ram_we_a) begin
         if (q_a.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wr_a_unexpected: got addr %h data %h, expected no write", ram_addr_a, ram_dbw_a);
         end else
            check("wr_a", {8'h00, ram_addr_a, ram_dbw_a}, {8'h00, q_a.pop_front()});
      end
      if (ram_we_b) begin
         if (q_b.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wr_b_unexpected: got addr %h data %h, expected no write", ram_addr_b, ram_dbw_b);
         end else
            check("wr_b", {8'h00, ram_addr_b, ram_dbw_b}, {8'h00, q_b.pop_front()});
      end
   end

   task automatic push_a(input int n);
      for (int i = 0; i < n; i++)
         q_a.push_back({16'hFF00 + 16'(i), rom_val(8'(i))});
   endtask

   // edges from the next one until done rises on A; 0 if never
   task automatic count_done_a(input int limit, output int first_done);
      first_done = 0;
      for (int e = 1; e <= limit; e++) begin
         @(posedge clk); #1;
         if (done_a) begin first_done = e; break; end
      end
   endtask

   initial begin
      int first_we, first_done, bad_seq, found;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_halt", 32'(cpu_halt_a), 32'd1);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_rom_cs", 32'(rom_cs_a), 32'd0);
      check("rst_ram_we", 32'(ram_we_a), 32'd0);

      // default copy, with CPU-side noise and ignored restart pulses
      @(negedge clk);
      rst_a = 1'b0;
      push_a(256);
      first_we = 0; first_done = 0; bad_seq = 0;
      for (int e = 1; e <= 300; e++) begin
         @(posedge clk); #1;
         if (ram_we_a && first_we == 0) first_we = e;
         if (e <= 256 && !(rom_cs_a === 1'b1 && rom_addr_a === 8'(e - 1))) bad_seq++;
         if (done_a) begin first_done = e; break; end
         if (e < 250) begin
            cpu_rom_cs_a   = 1'($urandom);
            cpu_rom_addr_a = 8'($urandom);
            restart_a      = (e % 37 == 5);
         end else begin
            cpu_rom_cs_a = 1'b0;
            restart_a    = 1'b0;
         end
      end
      check("first_we_edge", 32'(first_we), 32'd2);
      check("rom_addr_seq_errors", 32'(bad_seq), 32'd0);
      check("done_edge", 32'(first_done), 32'd258);
      check("halt_after_done", 32'(cpu_halt_a), 32'd0);
      check("ram_ff00", 32'(ram_a[16'hFF00]), 32'h0A5);
      check("ram_ff3c", 32'(ram_a[16'hFF3C]), 32'h099);
      check("ram_ffff", 32'(ram_a[16'hFFFF]), 32'h05A);
      check("q_a_drained_1", 32'(q_a.size()), 32'd0);

      // CPU owns the ROM in DONE
      cpu_rom_cs_a   = 1'b1;
      cpu_rom_addr_a = 8'h3C;
      #1;
      check("cpu_rom_cs_pass", 32'(rom_cs_a), 32'd1);
      check("cpu_rom_addr_pass", 32'(rom_addr_a), 32'h3C);
      @(posedge clk); #1;
      check("cpu_rom_dbr", 32'(cpu_rom_dbr_a), 32'h99);
      check("done_no_we", 32'(ram_we_a), 32'd0);
      cpu_rom_cs_a = 1'b0;

      // restart from DONE
      @(negedge clk);
      restart_a = 1'b1;
      push_a(256);
      @(posedge clk); #1;
      restart_a = 1'b0;
      check("restart_halt", 32'(cpu_halt_a), 32'd1);
      check("restart_done", 32'(done_a), 32'd0);
      count_done_a(300, first_done);
      check("restart_done_edge", 32'(first_done), 32'd257);
      check("q_a_drained_2", 32'(q_a.size()), 32'd0);

      // reset mid-copy at offset 100: offsets 0..99 land, then a full recopy
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      push_a(100);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rom_cs_a && rom_addr_a == 8'd100) begin found = 1; break; end
      end
      check("reached_offset_100", 32'(found), 32'd1);
      rst_a = 1'b1;
      push_a(256);
      @(negedge clk);
      check("midrst_done", 32'(done_a), 32'd0);
      rst_a = 1'b0;
      count_done_a(300, first_done);
      check("midrst_done_edge", 32'(first_done), 32'd258);
      check("q_a_drained_3", 32'(q_a.size()), 32'd0);

      // wrapping destination, LEN=32
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 0; i < 32; i++)
         q_b.push_back({16'hFFF0 + 16'(i), rom_val(8'(i))});
      first_done = 0;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (done_b) begin first_done = e; break; end
      end
      check("b_done_edge", 32'(first_done), 32'd34);
      check("b_halt", 32'(cpu_halt_b), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("b_ram_fff0", 32'(ram_b[16'hFFF0]), 32'h0A5);
      check("b_ram_0000", 32'(ram_b[16'h0000]), 32'h0B5);
      check("b_ram_000f", 32'(ram_b[16'h000F]), 32'h0BA);
      check("q_b_drained", 32'(q_b.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
